// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundle of the signals exchanged between the pipeline (master) and the
//   hazard controller (slave).
//   Pipeline -> controller : ID-stage instruction fields, redirect, mem ready
//   Controller -> pipeline : issue/hold/bubble/flush/freeze controls,
//                            watchdog error, perf counters
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int AW    = 5,
  parameter int CNT_W = 16
);
  logic             i_id_valid;
  logic [AW-1:0]    i_id_rs1;
  logic [AW-1:0]    i_id_rs2;
  logic             i_id_use_rs1;
  logic             i_id_use_rs2;
  logic [AW-1:0]    i_id_rd;
  logic             i_id_is_load;
  logic             i_redirect;
  logic             i_mem_ready;

  logic             o_issue;
  logic             o_hold_pc;
  logic             o_hold_ifid;
  logic             o_bubble_idex;
  logic             o_flush_ifid;
  logic             o_flush_exm;
  logic             o_freeze;
  logic             o_mem_timeout;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  // Pipeline side
  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_id_rd, i_id_is_load, i_redirect, i_mem_ready,
    input  o_issue, o_hold_pc, o_hold_ifid, o_bubble_idex, o_flush_ifid,
           o_flush_exm, o_freeze, o_mem_timeout, o_stall_cnt, o_flush_cnt
  );

  // Hazard controller side
  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_id_rd, i_id_is_load, i_redirect, i_mem_ready,
    output o_issue, o_hold_pc, o_hold_ifid, o_bubble_idex, o_flush_ifid,
           o_flush_exm, o_freeze, o_mem_timeout, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for the 5-stage RV32I core.
//   - Load-use: per-register pending mask, LOAD_LAT cycles deep.
//   - Redirect: squashes IF/ID, ID/EX, EX/MEM and cancels the load in EX.
//   - Memory wait: freezes the pipe; watchdog enters a sticky error state
//     after MEM_TIMEOUT consecutive not-ready cycles.
// Ports
//   clk    : core clock
//   reset  : asynchronous, active-low reset
//   hz     : hazard_ctrl_if.slave (ID fields, redirect, mem ready in;
//            pipeline controls, watchdog flag and perf counters out)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int NREG        = 32,
  parameter int AW          = 5,
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [NREG-1:0]  pend;
  logic             freeze;
  logic             hazard;
  logic             redirect_act;
  logic             hazard_act;
  logic             issue;

  // ---------------------------------------------------------------------------
  // Scoreboard: one shift mask per architectural register. x0 has no storage.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_x0
        assign pend[gi] = 1'b0;
      end else begin : g_reg
        logic [LOAD_LAT-1:0] pm_q, pm_d;
        logic [LOAD_LAT-1:0] aged;
        logic                set;

        always_comb begin
          set  = issue && hz.i_id_is_load && (hz.i_id_rd == AW'(gi));
          // An accepted redirect kills the load that just entered EX (bit0)
          aged = pm_q & ~LOAD_LAT'(redirect_act);
          pm_d = pm_q;
          if (!freeze) begin
            pm_d = (aged << 1) | LOAD_LAT'(set);
          end
        end

        always_ff @(posedge clk or negedge reset) begin
          if (!reset) pm_q <= '0;
          else        pm_q <= pm_d;
        end

        assign pend[gi] = |pm_q;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Per-cycle priority: freeze > redirect > load-use hazard > issue
  // ---------------------------------------------------------------------------
  always_comb begin
    freeze = (state_q != ST_RUN) || !hz.i_mem_ready;
    hazard = hz.i_id_valid &&
             ((hz.i_id_use_rs1 && pend[hz.i_id_rs1]) ||
              (hz.i_id_use_rs2 && pend[hz.i_id_rs2]));
    redirect_act = 1'b0;
    hazard_act   = 1'b0;
    issue        = 1'b0;
    if (!freeze) begin
      if (hz.i_redirect)  redirect_act = 1'b1;
      else if (hazard)    hazard_act   = 1'b1;
      else                issue        = hz.i_id_valid;
    end
  end

  assign hz.o_issue       = issue;
  assign hz.o_hold_pc     = hazard_act;
  assign hz.o_hold_ifid   = hazard_act;
  assign hz.o_bubble_idex = hazard_act || redirect_act;
  assign hz.o_flush_ifid  = redirect_act;
  assign hz.o_flush_exm   = redirect_act;
  assign hz.o_freeze      = freeze;
  assign hz.o_mem_timeout = (state_q == ST_ERR);
  assign hz.o_stall_cnt   = stall_cnt_q;
  assign hz.o_flush_cnt   = flush_cnt_q;

  // ---------------------------------------------------------------------------
  // Memory-wait watchdog. wcnt counts consecutive not-ready cycles; the RUN
  // cycle that first sees not-ready counts as the first one.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_RUN: begin
        if (!hz.i_mem_ready) begin
          state_d = ST_WAIT;
          wcnt_d  = 8'd1;
        end
      end
      ST_WAIT: begin
        if (hz.i_mem_ready) begin
          // Still frozen this cycle; the pipe releases on the next one
          state_d = ST_RUN;
          wcnt_d  = 8'd0;
        end else if (wcnt_q == 8'(MEM_TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
  end

  // Counters only move on accepted events, so they hold while frozen
  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(hazard_act);
    flush_cnt_d = flush_cnt_q + CNT_W'(redirect_act);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wcnt_q      <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Two controllers driven by the same stimulus:
//     dut0 : LOAD_LAT=1, MEM_TIMEOUT=16
//     dut1 : LOAD_LAT=3, MEM_TIMEOUT=4
//   Reference model: a list of in-flight loads with their age in accepted
//   cycles, and a run-length count of consecutive not-ready cycles.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.AW(5), .CNT_W(16)) hz0 ();
  hazard_ctrl_if #(.AW(5), .CNT_W(16)) hz1 ();

  hazard_ctrl #(.NREG(32), .AW(5), .LOAD_LAT(1), .MEM_TIMEOUT(16), .CNT_W(16))
    dut0 (.clk(clk), .reset(reset), .hz(hz0));
  hazard_ctrl #(.NREG(32), .AW(5), .LOAD_LAT(3), .MEM_TIMEOUT(4), .CNT_W(16))
    dut1 (.clk(clk), .reset(reset), .hz(hz1));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int lat_m [2] = '{1, 3};
  int to_m  [2] = '{16, 4};

  // model state
  bit sl_vld [2][8];
  int sl_rd  [2][8];
  int sl_age [2][8];
  int zrun   [2];
  bit prev_zero [2];
  bit err_m  [2];
  int stall_m [2];
  int flush_m [2];

  // current inputs
  bit in_valid, in_u1, in_u2, in_ld, in_redir, in_ready;
  int in_rs1, in_rs2, in_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) sl_vld[i][k] = 1'b0;
      zrun[i] = 0; prev_zero[i] = 1'b0; err_m[i] = 1'b0;
      stall_m[i] = 0; flush_m[i] = 0;
    end
  endtask

  function automatic bit pend_m(int i, int r);
    if (r == 0) return 1'b0;
    for (int k = 0; k < 8; k++)
      if (sl_vld[i][k] && sl_rd[i][k] == r && sl_age[i][k] >= 1 && sl_age[i][k] <= lat_m[i])
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic calc(input int i, output bit frz, output bit redir, output bit haz, output bit iss);
    frz   = err_m[i] || prev_zero[i] || !in_ready;
    redir = !frz && in_redir;
    haz   = !frz && !redir && in_valid &&
            ((in_u1 && pend_m(i, in_rs1)) || (in_u2 && pend_m(i, in_rs2)));
    iss   = !frz && !redir && !haz && in_valid;
  endtask

  function automatic logic [7:0] obs_ctrl(int i);
    if (i == 0)
      return {hz0.o_issue, hz0.o_hold_pc, hz0.o_hold_ifid, hz0.o_bubble_idex,
              hz0.o_flush_ifid, hz0.o_flush_exm, hz0.o_freeze, hz0.o_mem_timeout};
    return {hz1.o_issue, hz1.o_hold_pc, hz1.o_hold_ifid, hz1.o_bubble_idex,
            hz1.o_flush_ifid, hz1.o_flush_exm, hz1.o_freeze, hz1.o_mem_timeout};
  endfunction

  function automatic logic [15:0] obs_stall(int i);
    return (i == 0) ? hz0.o_stall_cnt : hz1.o_stall_cnt;
  endfunction

  function automatic logic [15:0] obs_flush(int i);
    return (i == 0) ? hz0.o_flush_cnt : hz1.o_flush_cnt;
  endfunction

  task automatic check_cycle();
    bit frz, redir, haz, iss;
    logic [7:0] ev;
    for (int i = 0; i < 2; i++) begin
      calc(i, frz, redir, haz, iss);
      ev = {iss, haz, haz, redir | haz, redir, redir, frz, err_m[i]};
      chk($sformatf("ctrl%0d", i), 32'(obs_ctrl(i)), 32'(ev));
      chk($sformatf("stall_cnt%0d", i), 32'(obs_stall(i)), 32'(stall_m[i] % 65536));
      chk($sformatf("flush_cnt%0d", i), 32'(obs_flush(i)), 32'(flush_m[i] % 65536));
    end
  endtask

  task automatic model_edge();
    bit frz, redir, haz, iss;
    for (int i = 0; i < 2; i++) begin
      calc(i, frz, redir, haz, iss);
      if (!frz) begin
        for (int k = 0; k < 8; k++) begin
          if (sl_vld[i][k]) begin
            if (redir && sl_age[i][k] == 1) sl_vld[i][k] = 1'b0;
            sl_age[i][k]++;
            if (sl_age[i][k] > lat_m[i]) sl_vld[i][k] = 1'b0;
          end
        end
        if (iss && in_ld) begin
          for (int k = 0; k < 8; k++) begin
            if (!sl_vld[i][k]) begin
              sl_vld[i][k] = 1'b1; sl_rd[i][k] = in_rd; sl_age[i][k] = 1;
              break;
            end
          end
        end
        if (haz)   stall_m[i]++;
        if (redir) flush_m[i]++;
      end
      if (!err_m[i]) begin
        if (!in_ready) begin
          zrun[i]++;
          prev_zero[i] = 1'b1;
          if (zrun[i] >= to_m[i]) err_m[i] = 1'b1;
        end else begin
          zrun[i] = 0;
          prev_zero[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic apply(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit ld, bit redir, bit rdy);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_u1 = u1; in_u2 = u2;
    in_rd = rd; in_ld = ld; in_redir = redir; in_ready = rdy;
    hz0.i_id_valid = v;  hz1.i_id_valid = v;
    hz0.i_id_rs1 = 5'(rs1); hz1.i_id_rs1 = 5'(rs1);
    hz0.i_id_rs2 = 5'(rs2); hz1.i_id_rs2 = 5'(rs2);
    hz0.i_id_use_rs1 = u1; hz1.i_id_use_rs1 = u1;
    hz0.i_id_use_rs2 = u2; hz1.i_id_use_rs2 = u2;
    hz0.i_id_rd = 5'(rd); hz1.i_id_rd = 5'(rd);
    hz0.i_id_is_load = ld; hz1.i_id_is_load = ld;
    hz0.i_redirect = redir; hz1.i_redirect = redir;
    hz0.i_mem_ready = rdy; hz1.i_mem_ready = rdy;
  endtask

  task automatic step(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit ld, bit redir, bit rdy);
    apply(v, rs1, rs2, u1, u2, rd, ld, redir, rdy);
    @(negedge clk);
    check_cycle();
    $display("cyc=%0d v=%0b rs1=%0d rs2=%0d u=%0b%0b rd=%0d ld=%0b redir=%0b rdy=%0b | d0 ctrl=%b st=%0d fl=%0d | d1 ctrl=%b st=%0d fl=%0d",
             cyc, v, rs1, rs2, u1, u2, rd, ld, redir, rdy,
             obs_ctrl(0), hz0.o_stall_cnt, hz0.o_flush_cnt,
             obs_ctrl(1), hz1.o_stall_cnt, hz1.o_flush_cnt);
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic lw(int rd, bit redir = 1'b0, bit rdy = 1'b1);
    step(1'b1, 0, 0, 1'b0, 1'b0, rd, 1'b1, redir, rdy);
  endtask

  task automatic dep(int rs1, int rs2, bit redir = 1'b0, bit rdy = 1'b1);
    step(1'b1, rs1, rs2, 1'b1, 1'b1, 10, 1'b0, redir, rdy);
  endtask

  task automatic idle(bit redir = 1'b0, bit rdy = 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, redir, rdy);
  endtask

  initial begin
    model_reset();
    apply(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    #12;
    check_cycle();
    chk("rst_ctrl1", 32'(obs_ctrl(1)), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_edge();
    #1;

    // load then dependent directly behind it
    lw(5);
    repeat (4) dep(5, 1);
    chk("t1_stall0", 32'(hz0.o_stall_cnt), 32'd1);
    chk("t2_stall1", 32'(hz1.o_stall_cnt), 32'd3);

    // dependent with two instructions in between (non-users of x5)
    lw(5);
    repeat (2) step(1'b1, 5, 5, 1'b0, 1'b0, 11, 1'b0, 1'b0, 1'b1);
    repeat (2) dep(5, 1);
    chk("t2b_stall0", 32'(hz0.o_stall_cnt), 32'd1);
    chk("t2b_stall1", 32'(hz1.o_stall_cnt), 32'd4);

    // x0 never hazards; non-users never hazard
    lw(0);
    repeat (2) dep(0, 0);
    lw(7);
    repeat (2) step(1'b1, 7, 7, 1'b0, 1'b0, 12, 1'b0, 1'b0, 1'b1);
    chk("t3_stall0", 32'(hz0.o_stall_cnt), 32'd1);
    chk("t3_stall1", 32'(hz1.o_stall_cnt), 32'd4);
    repeat (3) idle();

    // redirect cancels the load in EX
    lw(7);
    dep(7, 0, 1'b1);
    dep(7, 0);
    chk("t4_flush0", 32'(hz0.o_flush_cnt), 32'd1);
    chk("t4_flush1", 32'(hz1.o_flush_cnt), 32'd1);
    chk("t4_stall1", 32'(hz1.o_stall_cnt), 32'd4);

    // memory wait with pending load and redirect held
    lw(5);
    repeat (3) dep(5, 0, 1'b1, 1'b0);
    dep(5, 0, 1'b1, 1'b1);
    chk("t5_flush_frozen1", 32'(hz1.o_flush_cnt), 32'd1);
    dep(5, 0, 1'b1, 1'b1);
    dep(5, 0);
    chk("t5_flush0", 32'(hz0.o_flush_cnt), 32'd2);
    chk("t5_flush1", 32'(hz1.o_flush_cnt), 32'd2);
    chk("t5_stall1", 32'(hz1.o_stall_cnt), 32'd4);

    // watchdog timeout, sticky error, then async reset mid-error
    repeat (5) idle(1'b0, 1'b0);
    chk("t6_tmo1", 32'(hz1.o_mem_timeout), 32'd1);
    chk("t6_tmo0", 32'(hz0.o_mem_timeout), 32'd0);
    repeat (3) idle();
    chk("t6_sticky1", 32'(hz1.o_mem_timeout), 32'd1);
    chk("t6_frz1", 32'(hz1.o_freeze), 32'd1);
    chk("t6_frz0", 32'(hz0.o_freeze), 32'd0);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_cycle();
    chk("t6_rst_ctrl1", 32'(obs_ctrl(1)), 32'd0);
    chk("t6_rst_stall1", 32'(hz1.o_stall_cnt), 32'd0);
    chk("t6_rst_flush1", 32'(hz1.o_flush_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_edge();
    #1;

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 4) != 0, int'($urandom % 8), int'($urandom % 8),
           1'($urandom), 1'($urandom), int'($urandom % 8), 1'($urandom),
           ($urandom % 10) == 0, ($urandom % 8) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
